// File: rtl/pending_index_encoder_pkg.sv
// Shared constants, FSM state type and a popcount helper for the
// pending-index encoder.
package pending_index_encoder_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = IDX_W + 1;

  // ST_IDLE: nothing offered. ST_OFFER: out_index is a valid offer.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // Number of set bits in a request vector (0..WIDTH).
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/five_bit_decoder.sv
// 5-to-32 one-hot decoder.
module five_bit_decoder (
  input  logic [4:0]  in_code,
  output logic [31:0] out_onehot
);

  // Drive exactly one output line, selected by in_code.
  always_comb begin
    out_onehot = '0;
    out_onehot[in_code] = 1'b1;
  end

endmodule

// File: rtl/pending_index_encoder_search.sv
// Round-robin find-first-set: returns the first set bit of vec at or
// after position base, wrapping from WIDTH-1 back to 0.
module rr_priority_search
  import pending_index_encoder_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  input  logic [IDX_W-1:0] base,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  logic [IDX_W-1:0]   offs;

  // Rotate right by base so base lands at bit 0, find the lowest set bit,
  // then add base back (modulo WIDTH through the natural IDX_W wrap).
  always_comb begin
    dbl   = {vec, vec};
    rot   = dbl[base +: WIDTH];
    found = 1'b0;
    offs  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        offs  = IDX_W'(i);
      end
    end
    index = offs + base;
  end

endmodule

// File: rtl/pending_index_encoder.sv
// Round-robin pending-request encoder. Set pulses accumulate into a
// pending bitmap; one pending bit at a time is offered as an index over
// a valid/ready handshake and cleared when accepted.
//
// Handshake: out_valid/out_index are registered. Once out_valid is high,
// out_index holds until the cycle in which out_ready is also high (an
// accept) or clear_all/reset drops the offer. An accept with bits still
// pending loads the next offer in the same edge, so there is no bubble.
module pending_index_encoder
  import pending_index_encoder_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic             clear_all,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_onehot,
  output logic [WIDTH-1:0] pending,
  output logic [CNT_W-1:0] count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic [WIDTH-1:0] idx_onehot;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] p_next;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] base;
  logic             sel_found;
  logic [IDX_W-1:0] sel_index;

  // Decode of the current offer; used both for clearing and for out_onehot.
  five_bit_decoder u_dec (
    .in_code    (idx_q),
    .out_onehot (idx_onehot)
  );

  rr_priority_search u_search (
    .vec   (p_next),
    .base  (base),
    .found (sel_found),
    .index (sel_index)
  );

  // Bitmap update and search base. A set on the bit being accepted wins.
  always_comb begin
    accept   = (state_q == ST_OFFER) && out_ready;
    clr_mask = accept ? idx_onehot : '0;
    p_next   = (p_q & ~clr_mask) | set;
    idx_inc  = idx_q + IDX_W'(1);
    base     = accept ? idx_inc : ptr_q;
  end

  // Next-state logic: clear_all overrides everything except ptr.
  always_comb begin
    state_d = state_q;
    p_d     = p_next;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    count_d = popcount(p_next);
    if (clear_all) begin
      state_d = ST_IDLE;
      p_d     = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            idx_d   = sel_index;
            state_d = ST_OFFER;
          end
        end
        ST_OFFER: begin
          // Without ready the offer is frozen; new sets only touch P.
          if (out_ready) begin
            ptr_d = idx_inc;
            if (sel_found) begin
              idx_d = sel_index;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Outputs are straight from flops; onehot is gated so it is zero when idle.
  always_comb begin
    out_valid  = (state_q == ST_OFFER);
    out_index  = idx_q;
    out_onehot = out_valid ? idx_onehot : '0;
    pending    = p_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_pending_index_encoder.sv
// Bench for pending_index_encoder: directed test-plan sequences plus a
// random phase, all checked against a behavioural model via a queue.
module tb_pending_index_encoder;
  import pending_index_encoder_pkg::*;

  localparam int EXP_W = 1 + IDX_W + WIDTH + CNT_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] set;
  logic             clear_all;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [WIDTH-1:0] out_onehot;
  logic [WIDTH-1:0] pending;
  logic [CNT_W-1:0] count;

  always #5 clock = ~clock;

  pending_index_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .set        (set),
    .clear_all  (clear_all),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_onehot (out_onehot),
    .pending    (pending),
    .count      (count)
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_p;
  logic [IDX_W-1:0] m_ptr;
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Linear wrap-around scan; returns {found, index}.
  function automatic logic [IDX_W:0] scan_from(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] b);
    for (int k = 0; k < WIDTH; k++) begin
      int j;
      j = (int'(b) + k) % WIDTH;
      if (v[j]) return {1'b1, IDX_W'(j)};
    end
    return '0;
  endfunction

  // Advance the model by one clock with the inputs of that cycle, push expectation.
  task automatic model_step(input logic [WIDTH-1:0] s, input logic clr, input logic rdy, input logic rst);
    logic             acc;
    logic [WIDTH-1:0] pn;
    logic [IDX_W-1:0] b;
    logic [IDX_W:0]   r;
    if (rst) begin
      m_p = '0; m_ptr = '0; m_valid = 1'b0; m_idx = '0;
    end else if (clr) begin
      m_p = '0; m_valid = 1'b0;
    end else begin
      acc = m_valid && rdy;
      pn  = m_p;
      if (acc) pn[m_idx] = 1'b0;
      pn = pn | s;
      b  = acc ? IDX_W'((int'(m_idx) + 1) % WIDTH) : m_ptr;
      if (acc) m_ptr = b;
      if (!m_valid || rdy) begin
        r = scan_from(pn, b);
        m_valid = r[IDX_W];
        if (r[IDX_W]) m_idx = r[IDX_W-1:0];
      end
      m_p = pn;
    end
    exp_q.push_back({m_valid, m_idx, m_p, CNT_W'($countones(m_p))});
  endtask

  task automatic sb_compare();
    logic [EXP_W-1:0] e;
    logic             ev;
    logic [IDX_W-1:0] ei;
    logic [WIDTH-1:0] ep;
    logic [CNT_W-1:0] ec;
    logic [WIDTH-1:0] eo;
    if (exp_q.size() == 0) begin
      check_eq("sb_queue_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    {ev, ei, ep, ec} = e;
    eo = ev ? (WIDTH'(1) << ei) : '0;
    check_eq("sb_valid", 64'(out_valid), 64'(ev));
    if (ev) check_eq("sb_index", 64'(out_index), 64'(ei));
    check_eq("sb_onehot", 64'(out_onehot), 64'(eo));
    check_eq("sb_pending", 64'(pending), 64'(ep));
    check_eq("sb_count", 64'(count), 64'(ec));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [WIDTH-1:0] s, input logic clr, input logic rdy, input logic rst = 1'b0);
    set = s; clear_all = clr; out_ready = rdy; reset = rst;
    @(posedge clock);
    model_step(s, clr, rdy, rst);
    #1;
    sb_compare();
  endtask

  task automatic expect_offer(input string tag, input logic v, input logic [IDX_W-1:0] i, input logic [CNT_W-1:0] c);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
    if (v) check_eq({tag, "_index"}, 64'(out_index), 64'(i));
    check_eq({tag, "_count"}, 64'(count), 64'(c));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set = '0; clear_all = 1'b0; out_ready = 1'b0; reset = 1'b1;
    m_p = '0; m_ptr = '0; m_valid = 1'b0; m_idx = '0;

    cycle('0, 0, 0, 1);
    cycle('0, 0, 0, 1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_index", 64'(out_index), 64'd0);
    check_eq("rst_onehot", 64'(out_onehot), 64'd0);
    check_eq("rst_pending", 64'(pending), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);

    // Single bit, immediate accept.
    cycle(32'h0000_0001, 0, 1);
    expect_offer("single", 1, 0, 1);
    check_eq("single_onehot", 64'(out_onehot), 64'h1);
    cycle('0, 0, 1);
    expect_offer("single_done", 0, 0, 0);
    check_eq("single_pending", 64'(pending), 64'd0);

    // Multi-hot drain from ptr=0: 0, 4, 31.
    cycle('0, 0, 0, 1);
    cycle(32'h8000_0011, 0, 1);
    expect_offer("multi0", 1, 0, 3);
    cycle('0, 0, 1);
    expect_offer("multi4", 1, 4, 2);
    cycle('0, 0, 1);
    expect_offer("multi31", 1, 31, 1);
    cycle('0, 0, 1);
    expect_offer("multi_done", 0, 0, 0);

    // Wrap: after 31 accepted, bit 0 before bit 5.
    cycle(32'h0000_0021, 0, 1);
    expect_offer("wrap0", 1, 0, 2);
    cycle('0, 0, 1);
    expect_offer("wrap5", 1, 5, 1);
    cycle('0, 0, 1);

    // Round-robin: after 4 accepted, 9 before 2.
    cycle(32'h0000_0010, 0, 1);
    expect_offer("rr4", 1, 4, 1);
    cycle('0, 0, 1);
    cycle(32'h0000_0204, 0, 1);
    expect_offer("rr9", 1, 9, 2);
    cycle('0, 0, 1);
    expect_offer("rr2", 1, 2, 1);
    cycle('0, 0, 1);
    expect_offer("rr_done", 0, 0, 0);

    // Stall on index 3 while bit 1 is set; re-set of 3 in its accept cycle.
    cycle(32'h0000_0008, 0, 0);
    expect_offer("stall_start", 1, 3, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(32'h0000_0002, 0, 0);
      expect_offer("stall_hold", 1, 3, 2);
    end
    cycle(32'h0000_0008, 0, 1);
    expect_offer("stall_next1", 1, 1, 2);
    check_eq("stall_pending", 64'(pending), 64'h0A);
    cycle('0, 0, 1);
    expect_offer("stall_reoffer3", 1, 3, 1);
    cycle('0, 0, 1);
    expect_offer("stall_done", 0, 0, 0);

    // All 32 bits, continuous ready.
    cycle('0, 0, 0, 1);
    cycle(32'hFFFF_FFFF, 0, 1);
    expect_offer("full0", 1, 0, 32);
    for (int i = 1; i < 32; i++) begin
      cycle('0, 0, 1);
      expect_offer("full_seq", 1, IDX_W'(i), CNT_W'(32 - i));
    end
    cycle('0, 0, 1);
    expect_offer("full_done", 0, 0, 0);

    // clear_all mid-offer, and clear_all overriding a concurrent set.
    cycle(32'h0000_3F00, 0, 0);
    expect_offer("clr_pre", 1, 8, 6);
    cycle('0, 1, 1);
    expect_offer("clr_post", 0, 0, 0);
    check_eq("clr_pending", 64'(pending), 64'd0);
    cycle(32'h0000_0005, 1, 0);
    check_eq("clr_set_ignored", 64'(pending), 64'd0);

    // Reset mid-operation.
    cycle(32'h0000_00F0, 0, 0);
    cycle('0, 0, 1);
    expect_offer("rstmid_pre", 1, 5, 3);
    cycle('0, 0, 0, 1);
    check_eq("rstmid_valid", 64'(out_valid), 64'd0);
    check_eq("rstmid_index", 64'(out_index), 64'd0);
    check_eq("rstmid_onehot", 64'(out_onehot), 64'd0);
    check_eq("rstmid_pending", 64'(pending), 64'd0);
    check_eq("rstmid_count", 64'(count), 64'd0);
    cycle(32'h0000_0021, 0, 0);
    expect_offer("rstmid_ptr0", 1, 0, 2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] s;
      s = '0;
      if ($urandom_range(0, 2) == 0) s = WIDTH'(1) << $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) s = s | (WIDTH'(1) << $urandom_range(0, 31));
      if ($urandom_range(0, 30) == 0) s = $urandom;
      cycle(s, ($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 150) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
